// File: rtl/timer_scheduler_if.sv
// Job-post / completion bus between requesters and the shared busy-timer scheduler.
interface timer_scheduler_if #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned CNT_WIDTH = 16
);
   localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]           request__ENA;
   logic [NUM_REQ-1:0]           request__RDY;
   logic [NUM_REQ*CNT_WIDTH-1:0] request_amount;
   logic                         busy;
   logic                         busy__RDY;
   logic [ID_W-1:0]              owner;
   logic                         done__ENA;
   logic [ID_W-1:0]              done_id;

   modport master (
      output request__ENA, request_amount,
      input  request__RDY, busy, busy__RDY, owner, done__ENA, done_id
   );

   modport slave (
      input  request__ENA, request_amount,
      output request__RDY, busy, busy__RDY, owner, done__ENA, done_id
   );
endinterface

// File: rtl/timer_scheduler.sv
// One shared down-counting timer; round-robin grants posted jobs and pulses done with the owner id.
module timer_scheduler #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned MAX_AMOUNT = 22,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input logic              CLK,
   input logic              RST,
   timer_scheduler_if.slave bus
);
   localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   pending_q, pending_d;
   logic [CNT_WIDTH-1:0] amt_q [NUM_REQ];
   logic [CNT_WIDTH-1:0] amt_d [NUM_REQ];
   logic [CNT_WIDTH-1:0] counter_q, counter_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]      owner_q, owner_d;

   logic [NUM_REQ-1:0]   rot;
   logic [ID_W:0]        cand;
   logic [ID_W:0]        win_inc;
   logic                 found;
   logic [ID_W-1:0]      winner;

   function automatic logic [CNT_WIDTH-1:0] clamp_amt(input logic [CNT_WIDTH-1:0] a);
      if (a == '0) return CNT_WIDTH'(1);
      if (a > CNT_WIDTH'(MAX_AMOUNT)) return CNT_WIDTH'(MAX_AMOUNT);
      return a;
   endfunction

   // Round-robin search: rotate pending so bit 0 is rr_ptr, take the first set bit.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      rot    = NUM_REQ'({pending_q, pending_q} >> rr_ptr_q);
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
         if (!found && rot[k]) begin
            found  = 1'b1;
            winner = ID_W'(cand);
         end
      end
   end

   // Next-state: posts are latched in any state; grant in IDLE, countdown in RUN.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      amt_d     = amt_q;
      counter_d = counter_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      win_inc   = {1'b0, winner} + (ID_W+1)'(1);

      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.request__ENA[i] && !pending_q[i]) begin
            pending_d[i] = 1'b1;
            amt_d[i]     = clamp_amt(bus.request_amount[i*CNT_WIDTH +: CNT_WIDTH]);
         end
      end

      case (state_q)
         IDLE: begin
            if (found) begin
               counter_d         = amt_q[winner] - CNT_WIDTH'(1);
               owner_d           = winner;
               pending_d[winner] = 1'b0;
               rr_ptr_d          = (win_inc == (ID_W+1)'(NUM_REQ)) ? '0 : ID_W'(win_inc);
               state_d           = RUN;
            end
         end
         RUN: begin
            if (counter_q != '0) counter_d = counter_q - CNT_WIDTH'(1);
            else                 state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         pending_q <= '0;
         amt_q     <= '{default: '0};
         counter_q <= '0;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         amt_q     <= amt_d;
         counter_q <= counter_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
      end
   end

   assign bus.request__RDY = ~pending_q;
   assign bus.busy         = (state_q == RUN);
   assign bus.busy__RDY    = 1'b1;
   assign bus.owner        = owner_q;
   assign bus.done__ENA    = (state_q == RUN) && (counter_q == '0);
   assign bus.done_id      = owner_q;

   // Clamp guarantees the countdown never reaches MAX_AMOUNT.
   counter_below_max: assert property (@(posedge CLK) disable iff (RST)
      counter_q < CNT_WIDTH'(MAX_AMOUNT));
endmodule

// File: tb/tb_timer_scheduler.sv
// Scoreboard bench for timer_scheduler: expected done events (id, cycle) queued at post time.
module tb_timer_scheduler;
   localparam int unsigned NUM_REQ   = 4;
   localparam int unsigned CNT_WIDTH = 16;

   typedef struct {
      int id;
      int cyc;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   timer_scheduler_if #(.NUM_REQ(NUM_REQ), .CNT_WIDTH(CNT_WIDTH)) bus ();

   timer_scheduler #(.NUM_REQ(NUM_REQ), .MAX_AMOUNT(22), .CNT_WIDTH(CNT_WIDTH)) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Completion monitor: every done pulse must match the head of the scoreboard.
   always @(negedge CLK) begin
      if (!RST && bus.done__ENA) begin
         if (q.size() == 0) begin
            check("done_unexp", 32'(bus.done__ENA), 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("done_id", 32'(bus.done_id), 32'(e.id));
            check("done_cyc", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Called at a negedge; returns the clock edge that sampled the post, ending at the next negedge.
   task automatic post(input logic [NUM_REQ-1:0] mask, input int amt, output int edge_n);
      bus.request__ENA = mask;
      for (int i = 0; i < NUM_REQ; i++)
         bus.request_amount[i*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(amt);
      @(negedge CLK);
      bus.request__ENA = '0;
      edge_n = cyc;
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while (q.size() != 0 && n < limit) begin
         @(negedge CLK);
         n++;
      end
      check("drain", 32'(q.size()), 32'd0);
      q.delete();
      repeat (4) @(negedge CLK);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int g;
      bus.request__ENA   = '0;
      bus.request_amount = '0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;

      // Reset state
      check("rst_rdy", 32'(bus.request__RDY), 32'hF);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done__ENA), 32'd0);
      check("rst_owner", 32'(bus.owner), 32'd0);
      check("rst_done_id", 32'(bus.done_id), 32'd0);
      check("busy_rdy", 32'(bus.busy__RDY), 32'd1);

      // Single job: req1 amount 5
      post(4'b0010, 5, p);
      q.push_back('{1, p + 5});
      check("single_rdy_pend", 32'(bus.request__RDY), 32'hD);
      @(negedge CLK);
      check("single_busy", 32'(bus.busy), 32'd1);
      check("single_owner", 32'(bus.owner), 32'd1);
      check("single_rdy_free", 32'(bus.request__RDY), 32'hF);
      while (cyc < p + 6) @(negedge CLK);
      check("single_idle", 32'(bus.busy), 32'd0);
      check("single_owner_hold", 32'(bus.owner), 32'd1);
      drain(20);

      // Clamping: 0 -> 1 cycle, 100 -> 22 cycles
      post(4'b0001, 0, p);
      q.push_back('{0, p + 1});
      drain(10);
      post(4'b0100, 100, p);
      q.push_back('{2, p + 22});
      drain(40);

      // Round-robin from rr_ptr=0: four simultaneous posts of amount 2
      do_reset();
      post(4'b1111, 2, p);
      g = p;
      for (int i = 0; i < 4; i++) begin
         q.push_back('{i, g + 2});
         g = g + 3;
      end
      drain(40);
      post(4'b1001, 2, p);
      q.push_back('{0, p + 2});
      q.push_back('{3, p + 5});
      drain(20);
      post(4'b0001, 1, p);
      q.push_back('{0, p + 1});
      drain(10);
      post(4'b1001, 2, p);
      q.push_back('{3, p + 2});
      q.push_back('{0, p + 5});
      drain(20);

      // Owner re-posts during its own run while req1 waits
      post(4'b0100, 6, p);
      post(4'b0010, 3, g);
      post(4'b0100, 2, g);
      q.push_back('{2, p + 6});
      q.push_back('{1, p + 10});
      q.push_back('{2, p + 13});
      drain(40);

      // Post while already pending is ignored
      post(4'b1000, 5, p);
      post(4'b0001, 4, g);
      check("ign_rdy0", 32'(bus.request__RDY[0]), 32'd0);
      post(4'b0001, 9, g);
      q.push_back('{3, p + 5});
      q.push_back('{0, p + 10});
      drain(40);
      repeat (12) @(negedge CLK);

      // Reset mid-run with two pending jobs
      post(4'b0010, 10, p);
      post(4'b0101, 3, g);
      check("mid_busy_before", 32'(bus.busy), 32'd1);
      do_reset();
      check("mid_busy", 32'(bus.busy), 32'd0);
      check("mid_rdy", 32'(bus.request__RDY), 32'hF);
      check("mid_done", 32'(bus.done__ENA), 32'd0);
      check("mid_owner", 32'(bus.owner), 32'd0);
      repeat (15) @(negedge CLK);
      check("mid_stay_idle", 32'(bus.busy), 32'd0);
      post(4'b0100, 3, p);
      q.push_back('{2, p + 3});
      @(negedge CLK);
      check("post_rst_owner", 32'(bus.owner), 32'd2);
      drain(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
